fifo_sync_param: RTL

//   Parametrised single-clock FIFO; next generation of the fixed 8-bit/16-entry fifo.

---
 rtl/fifo_sync_param.sv | 105 ++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with handshakes, occupancy count, almost flags and error pulses.
// Define FIFO_PEEK_EN to add the random-access peek port (read_address/peek_data/peek_valid).
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
`ifdef FIFO_PEEK_EN
  input  logic [AW-1:0]     read_address,
  output logic [DATA_W-1:0] peek_data,
  output logic              peek_valid,
`endif
  output logic              underflow
);

  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;

  // Full/empty come from the occupancy count, so pointers never need an extra wrap bit.
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));

  always_comb begin
    rd_acc      = rd_en & ~empty;
    wr_acc      = wr_en & (~full | rd_acc);
    wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
    data_out_d  = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
    rd_valid_d  = rd_acc;
    overflow_d  = wr_en & full & ~rd_acc;
    underflow_d = rd_en & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_PEEK_EN
  logic [AW-1:0] peek_ptr;

  assign peek_ptr   = rd_ptr_q + read_address;
  assign peek_data  = mem_q[peek_ptr];
  assign peek_valid = ({1'b0, read_address} < count_q);
`endif

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
